// File: rtl/uart_rx_pkt_decoder_if.sv
// ----------------------------------------------------------------------------
// uart_rx_pkt_decoder_if
// Purpose : bundles the byte stream coming from the UART receiver and the
//           valid/ready payload stream going to the command logic.
// Signals :
//   i_Rx_DV      one-cycle pulse, i_Rx_Byte holds a new received byte
//   i_Rx_Byte    received byte, valid only with i_Rx_DV
//   o_Pkt_Valid  payload byte available on o_Pkt_Byte
//   i_Pkt_Ready  consumer accepts byte when o_Pkt_Valid & i_Pkt_Ready
//   o_Pkt_Byte   current payload byte
//   o_Pkt_Last   high with o_Pkt_Valid on the final payload byte
//   o_Pkt_Len    LEN of the packet being output, held until next good packet
// Modports:
//   master  the decoder (sinks the rx stream, sources the payload stream)
//   slave   the surrounding logic (UART receiver + command consumer)
// ----------------------------------------------------------------------------
interface uart_rx_pkt_decoder_if;
   logic       i_Rx_DV;
   logic [7:0] i_Rx_Byte;
   logic       o_Pkt_Valid;
   logic       i_Pkt_Ready;
   logic [7:0] o_Pkt_Byte;
   logic       o_Pkt_Last;
   logic [7:0] o_Pkt_Len;

   modport master (
      input  i_Rx_DV,
      input  i_Rx_Byte,
      input  i_Pkt_Ready,
      output o_Pkt_Valid,
      output o_Pkt_Byte,
      output o_Pkt_Last,
      output o_Pkt_Len
   );

   modport slave (
      output i_Rx_DV,
      output i_Rx_Byte,
      output i_Pkt_Ready,
      input  o_Pkt_Valid,
      input  o_Pkt_Byte,
      input  o_Pkt_Last,
      input  o_Pkt_Len
   );
endinterface

// File: rtl/uart_rx_pkt_decoder.sv
// ----------------------------------------------------------------------------
// uart_rx_pkt_decoder
// Purpose : extracts framed packets (SYNC, LEN, LEN payload bytes, CHK) from
//           the UART receiver byte stream. CHK is the XOR of LEN and all
//           payload bytes. A good payload is buffered and then replayed on a
//           valid/ready byte stream; bad, oversized or stalled frames are
//           dropped and flagged with one-cycle error pulses.
// Ports   :
//   i_Clock        single clock, rising edge
//   i_Reset        synchronous, active-high reset
//   bus            uart_rx_pkt_decoder_if.master (rx stream in, payload out)
//   o_Busy         high whenever the decoder is not hunting for SYNC
//   o_Err_Chk      pulse: checksum mismatch, frame dropped
//   o_Err_Len      pulse: LEN==0 or LEN>MAX_LEN, frame dropped
//   o_Err_Timeout  pulse: inter-byte timeout, frame dropped
//   o_Err_Overrun  pulse: byte arrived while replaying and was discarded
// ----------------------------------------------------------------------------
module uart_rx_pkt_decoder #(
   parameter int         CLKS_PER_BIT = 217,
   parameter int         TIMEOUT_BITS = 20,
   parameter int         MAX_LEN      = 16,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
   input  logic                  i_Clock,
   input  logic                  i_Reset,
   uart_rx_pkt_decoder_if.master bus,
   output logic                  o_Busy,
   output logic                  o_Err_Chk,
   output logic                  o_Err_Len,
   output logic                  o_Err_Timeout,
   output logic                  o_Err_Overrun
);

   localparam int             TIMEOUT_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int             CNT_W         = $clog2(TIMEOUT_LIMIT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_LIMIT - 1);
   localparam int             IDX_W         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [7:0]     MAX_LEN_B     = 8'(MAX_LEN);

   typedef enum logic [2:0] {
      S_SYNC,
      S_LEN,
      S_PAYLOAD,
      S_CHK,
      S_OUT
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [7:0]       pkt_len;
   logic [7:0]       wr_idx;
   logic [7:0]       rd_idx;
   logic [7:0]       rd_nxt;
   logic [7:0]       run_xor;
   logic [CNT_W-1:0] to_cnt;
   logic [7:0]       pkt_buf [MAX_LEN];

   logic timed;
   logic to_expire;
   logic len_ok;
   logic chk_ok;
   logic xfer;
   logic err_chk_nxt;
   logic err_len_nxt;
   logic err_to_nxt;
   logic err_ovr_nxt;

   // Shared decode terms. A DV on the expiry cycle suppresses the timeout,
   // so the arriving byte always wins.
   assign timed     = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
   assign to_expire = timed && !bus.i_Rx_DV && (to_cnt == CNT_LAST);
   assign len_ok    = (bus.i_Rx_Byte != 8'd0) && (bus.i_Rx_Byte <= MAX_LEN_B);
   assign chk_ok    = (bus.i_Rx_Byte == run_xor);
   assign xfer      = bus.o_Pkt_Valid && bus.i_Pkt_Ready;
   assign rd_nxt    = rd_idx + 8'd1;

   // State register.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state <= S_SYNC;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. Bytes arriving during replay never leave S_OUT; the
   // only exit is the handshake on the last payload byte.
   always_comb begin
      state_nxt = state;
      case (state)
         S_SYNC: begin
            if (bus.i_Rx_DV && (bus.i_Rx_Byte == SYNC_BYTE)) state_nxt = S_LEN;
         end
         S_LEN: begin
            if (bus.i_Rx_DV)    state_nxt = len_ok ? S_PAYLOAD : S_SYNC;
            else if (to_expire) state_nxt = S_SYNC;
         end
         S_PAYLOAD: begin
            if (bus.i_Rx_DV) begin
               if (wr_idx == (pkt_len - 8'd1)) state_nxt = S_CHK;
            end else if (to_expire) begin
               state_nxt = S_SYNC;
            end
         end
         S_CHK: begin
            if (bus.i_Rx_DV)    state_nxt = chk_ok ? S_OUT : S_SYNC;
            else if (to_expire) state_nxt = S_SYNC;
         end
         S_OUT: begin
            if (xfer && bus.o_Pkt_Last) state_nxt = S_SYNC;
         end
         default: state_nxt = S_SYNC;
      endcase
   end

   // Output decode: busy flag and the next value of each error pulse. The
   // conditions are keyed on disjoint states, so at most one fires per cycle.
   always_comb begin
      o_Busy      = (state != S_SYNC);
      err_len_nxt = (state == S_LEN) && bus.i_Rx_DV && !len_ok;
      err_chk_nxt = (state == S_CHK) && bus.i_Rx_DV && !chk_ok;
      err_to_nxt  = to_expire;
      err_ovr_nxt = (state == S_OUT) && bus.i_Rx_DV;
   end

   // Payload buffer. Contents are don't-care after reset, so it carries no
   // reset and can map onto plain storage.
   always_ff @(posedge i_Clock) begin
      if ((state == S_PAYLOAD) && bus.i_Rx_DV) begin
         pkt_buf[wr_idx[IDX_W-1:0]] <= bus.i_Rx_Byte;
      end
   end

   // Inter-byte timeout counter. It only counts while a frame is being
   // collected, restarts on every received byte, and saturates at the
   // expiry value instead of wrapping.
   always_ff @(posedge i_Clock) begin
      if (i_Reset || !timed || bus.i_Rx_DV) begin
         to_cnt <= '0;
      end else if (to_cnt != CNT_LAST) begin
         to_cnt <= to_cnt + CNT_W'(1);
      end
   end

   // Frame datapath and registered outputs. The first payload byte is
   // loaded on the CHK byte so valid rises the very next cycle, and each
   // handshake preloads the following byte so a held-high ready sees no
   // bubbles. Without a handshake the output registers simply hold.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         pkt_len         <= 8'h00;
         wr_idx          <= 8'h00;
         rd_idx          <= 8'h00;
         run_xor         <= 8'h00;
         bus.o_Pkt_Valid <= 1'b0;
         bus.o_Pkt_Byte  <= 8'h00;
         bus.o_Pkt_Last  <= 1'b0;
         bus.o_Pkt_Len   <= 8'h00;
         o_Err_Chk       <= 1'b0;
         o_Err_Len       <= 1'b0;
         o_Err_Timeout   <= 1'b0;
         o_Err_Overrun   <= 1'b0;
      end else begin
         o_Err_Chk     <= err_chk_nxt;
         o_Err_Len     <= err_len_nxt;
         o_Err_Timeout <= err_to_nxt;
         o_Err_Overrun <= err_ovr_nxt;
         case (state)
            S_SYNC: begin
               if (bus.i_Rx_DV && (bus.i_Rx_Byte == SYNC_BYTE)) run_xor <= 8'h00;
            end
            S_LEN: begin
               if (bus.i_Rx_DV && len_ok) begin
                  pkt_len <= bus.i_Rx_Byte;
                  run_xor <= bus.i_Rx_Byte;
                  wr_idx  <= 8'h00;
               end
            end
            S_PAYLOAD: begin
               if (bus.i_Rx_DV) begin
                  run_xor <= run_xor ^ bus.i_Rx_Byte;
                  wr_idx  <= wr_idx + 8'd1;
               end
            end
            S_CHK: begin
               if (bus.i_Rx_DV && chk_ok) begin
                  bus.o_Pkt_Len   <= pkt_len;
                  rd_idx          <= 8'h00;
                  bus.o_Pkt_Valid <= 1'b1;
                  bus.o_Pkt_Byte  <= pkt_buf[0];
                  bus.o_Pkt_Last  <= (pkt_len == 8'd1);
               end
            end
            S_OUT: begin
               if (xfer) begin
                  if (bus.o_Pkt_Last) begin
                     bus.o_Pkt_Valid <= 1'b0;
                     bus.o_Pkt_Last  <= 1'b0;
                  end else begin
                     rd_idx         <= rd_nxt;
                     bus.o_Pkt_Byte <= pkt_buf[rd_nxt[IDX_W-1:0]];
                     bus.o_Pkt_Last <= (rd_nxt == (pkt_len - 8'd1));
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_pkt_decoder.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_pkt_decoder
// Purpose : directed, self-checking bench for uart_rx_pkt_decoder. Bytes are
//           driven on the falling edge as one-cycle DV pulses, and outputs are
//           sampled on the falling edge, half a cycle away from the active edge.
// ----------------------------------------------------------------------------
module tb_uart_rx_pkt_decoder;

   localparam int TIMEOUT_LIMIT = 20 * 217;

   logic clock;
   logic reset;
   logic busy;
   logic errChk;
   logic errLen;
   logic errTimeout;
   logic errOverrun;

   int checkCount = 0;
   int failCount  = 0;

   int errChkCount     = 0;
   int errLenCount     = 0;
   int errTimeoutCount = 0;
   int errOverrunCount = 0;
   int validCount      = 0;

   uart_rx_pkt_decoder_if bus ();

   uart_rx_pkt_decoder #(
      .CLKS_PER_BIT (217),
      .TIMEOUT_BITS (20),
      .MAX_LEN      (16),
      .SYNC_BYTE    (8'hA5)
   ) dut (
      .i_Clock       (clock),
      .i_Reset       (reset),
      .bus           (bus),
      .o_Busy        (busy),
      .o_Err_Chk     (errChk),
      .o_Err_Len     (errLen),
      .o_Err_Timeout (errTimeout),
      .o_Err_Overrun (errOverrun)
   );

   // 100 MHz free-running clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Pulse and valid counters. Sampling on the rising edge reads the values
   // settled during the previous cycle, so there is no race with the
   // falling-edge checks in the stimulus block.
   always @(posedge clock) begin
      if (errChk)          errChkCount++;
      if (errLen)          errLenCount++;
      if (errTimeout)      errTimeoutCount++;
      if (errOverrun)      errOverrunCount++;
      if (bus.o_Pkt_Valid) validCount++;
   end

   // Drive one received byte as a single-cycle DV pulse; returns on the
   // falling edge right after the byte was sampled.
   task automatic applyStimulus(input logic [7:0] b);
      @(negedge clock);
      bus.i_Rx_DV   = 1'b1;
      bus.i_Rx_Byte = b;
      @(negedge clock);
      bus.i_Rx_DV   = 1'b0;
      bus.i_Rx_Byte = 8'h00;
   endtask

   // Drive a sequence of back-to-back bytes.
   task automatic sendSeq(input logic [7:0] seq [$]);
      foreach (seq[i]) applyStimulus(seq[i]);
   endtask

   // Single comparison point.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   function automatic int errTotal();
      return errChkCount + errLenCount + errTimeoutCount + errOverrunCount;
   endfunction

   // Directed test sequence.
   initial begin
      logic [7:0] frame [$];
      int         snapErr;
      int         snapChk;
      int         snapLen;
      int         snapTo;
      int         snapOvr;
      int         snapValid;
      logic       stableOk;

      reset           = 1'b1;
      bus.i_Rx_DV     = 1'b0;
      bus.i_Rx_Byte   = 8'h00;
      bus.i_Pkt_Ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clock);
      checkOutput("rst_valid", bus.o_Pkt_Valid, 0);
      checkOutput("rst_byte",  bus.o_Pkt_Byte,  8'h00);
      checkOutput("rst_last",  bus.o_Pkt_Last,  0);
      checkOutput("rst_len",   bus.o_Pkt_Len,   8'h00);
      checkOutput("rst_busy",  busy,            0);
      checkOutput("rst_errs",  {errChk, errLen, errTimeout, errOverrun}, 4'b0000);
      reset = 1'b0;

      // Good 3-byte frame with ready held high
      $display("[TB] good 3-byte frame");
      bus.i_Pkt_Ready = 1'b1;
      snapErr = errTotal();
      frame = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      sendSeq(frame);
      checkOutput("t1_valid0", bus.o_Pkt_Valid, 1);
      checkOutput("t1_byte0",  bus.o_Pkt_Byte,  8'h11);
      checkOutput("t1_last0",  bus.o_Pkt_Last,  0);
      checkOutput("t1_len",    bus.o_Pkt_Len,   8'h03);
      checkOutput("t1_busy",   busy,            1);
      @(negedge clock);
      checkOutput("t1_valid1", bus.o_Pkt_Valid, 1);
      checkOutput("t1_byte1",  bus.o_Pkt_Byte,  8'h22);
      checkOutput("t1_last1",  bus.o_Pkt_Last,  0);
      @(negedge clock);
      checkOutput("t1_valid2", bus.o_Pkt_Valid, 1);
      checkOutput("t1_byte2",  bus.o_Pkt_Byte,  8'h33);
      checkOutput("t1_last2",  bus.o_Pkt_Last,  1);
      @(negedge clock);
      checkOutput("t1_valid_end", bus.o_Pkt_Valid, 0);
      checkOutput("t1_busy_end",  busy,            0);
      @(negedge clock);
      checkOutput("t1_no_errs", errTotal() - snapErr, 0);

      // Bad checksum, then a good 1-byte frame
      $display("[TB] bad checksum frame");
      snapChk   = errChkCount;
      snapValid = validCount;
      frame = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
      sendSeq(frame);
      checkOutput("t2_errchk",  errChk,          1);
      checkOutput("t2_valid",   bus.o_Pkt_Valid, 0);
      checkOutput("t2_busy",    busy,            0);
      repeat (2) @(negedge clock);
      checkOutput("t2_chk_once", errChkCount - snapChk,   1);
      checkOutput("t2_no_valid", validCount - snapValid, 0);
      frame = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
      sendSeq(frame);
      checkOutput("t2_good_valid", bus.o_Pkt_Valid, 1);
      checkOutput("t2_good_byte",  bus.o_Pkt_Byte,  8'h7E);
      checkOutput("t2_good_last",  bus.o_Pkt_Last,  1);
      checkOutput("t2_good_len",   bus.o_Pkt_Len,   8'h01);
      @(negedge clock);
      checkOutput("t2_good_end", bus.o_Pkt_Valid, 0);

      // LEN of zero and LEN above MAX_LEN
      $display("[TB] length errors");
      snapLen = errLenCount;
      frame = '{8'hA5, 8'h00};
      sendSeq(frame);
      checkOutput("t3_len0_err",  errLen, 1);
      checkOutput("t3_len0_busy", busy,   0);
      frame = '{8'hA5, 8'h11};
      sendSeq(frame);
      checkOutput("t3_len17_err",  errLen, 1);
      checkOutput("t3_len17_busy", busy,   0);
      frame = '{8'hA5, 8'h10};
      sendSeq(frame);
      checkOutput("t3_len16_busy", busy,   1);
      checkOutput("t3_len16_err",  errLen, 0);
      repeat (2) @(negedge clock);
      checkOutput("t3_len_count", errLenCount - snapLen, 2);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;

      // Inter-byte timeout after the AA byte
      $display("[TB] timeout");
      snapTo = errTimeoutCount;
      frame = '{8'hA5, 8'h02, 8'hAA};
      sendSeq(frame);
      repeat (TIMEOUT_LIMIT - 1) @(negedge clock);
      checkOutput("t4_to_early", errTimeout, 0);
      checkOutput("t4_busy_pre", busy,       1);
      @(negedge clock);
      checkOutput("t4_to_pulse", errTimeout, 1);
      checkOutput("t4_busy_post", busy,      0);
      @(negedge clock);
      checkOutput("t4_to_clear", errTimeout, 0);

      // Byte on the exact expiry cycle wins over the timeout
      snapTo = errTimeoutCount;
      frame = '{8'hA5, 8'h02, 8'hAA};
      sendSeq(frame);
      repeat (TIMEOUT_LIMIT - 2) @(negedge clock);
      applyStimulus(8'hBB);
      checkOutput("t4_edge_noto", errTimeout, 0);
      checkOutput("t4_edge_busy", busy,       1);
      applyStimulus(8'h13);
      checkOutput("t4_edge_valid", bus.o_Pkt_Valid, 1);
      checkOutput("t4_edge_byte0", bus.o_Pkt_Byte,  8'hAA);
      @(negedge clock);
      checkOutput("t4_edge_byte1", bus.o_Pkt_Byte,  8'hBB);
      checkOutput("t4_edge_last",  bus.o_Pkt_Last,  1);
      @(negedge clock);
      checkOutput("t4_edge_to_count", errTimeoutCount - snapTo, 0);

      // Backpressure and overrun during replay
      $display("[TB] backpressure and overrun");
      bus.i_Pkt_Ready = 1'b0;
      snapOvr = errOverrunCount;
      frame = '{8'hA5, 8'h02, 8'hC3, 8'h3C, 8'hFD};
      sendSeq(frame);
      checkOutput("t5_valid0", bus.o_Pkt_Valid, 1);
      checkOutput("t5_byte0",  bus.o_Pkt_Byte,  8'hC3);
      checkOutput("t5_last0",  bus.o_Pkt_Last,  0);
      stableOk = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (!(bus.o_Pkt_Valid && (bus.o_Pkt_Byte == 8'hC3) && !bus.o_Pkt_Last)) stableOk = 1'b0;
      end
      checkOutput("t5_stall_stable", stableOk, 1);
      applyStimulus(8'hA5);
      checkOutput("t5_overrun",    errOverrun,     1);
      checkOutput("t5_ovr_byte",   bus.o_Pkt_Byte, 8'hC3);
      checkOutput("t5_ovr_valid",  bus.o_Pkt_Valid, 1);
      bus.i_Pkt_Ready = 1'b1;
      @(negedge clock);
      bus.i_Pkt_Ready = 1'b0;
      checkOutput("t5_byte1", bus.o_Pkt_Byte, 8'h3C);
      checkOutput("t5_last1", bus.o_Pkt_Last, 1);
      stableOk = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         if (!(bus.o_Pkt_Valid && (bus.o_Pkt_Byte == 8'h3C) && bus.o_Pkt_Last)) stableOk = 1'b0;
      end
      checkOutput("t5_last_stable", stableOk, 1);
      bus.i_Pkt_Ready = 1'b1;
      @(negedge clock);
      checkOutput("t5_valid_end", bus.o_Pkt_Valid, 0);
      checkOutput("t5_busy_end",  busy,            0);
      checkOutput("t5_len",       bus.o_Pkt_Len,   8'h02);
      @(negedge clock);
      checkOutput("t5_ovr_count", errOverrunCount - snapOvr, 1);

      // Noise, reset mid-payload, clean decode afterwards
      $display("[TB] noise and mid-frame reset");
      snapErr = errTotal();
      frame = '{8'h00, 8'hFF, 8'h5A};
      sendSeq(frame);
      checkOutput("t6_noise_busy", busy, 0);
      frame = '{8'hA5, 8'h04, 8'h01, 8'h02};
      sendSeq(frame);
      checkOutput("t6_mid_busy", busy, 1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checkOutput("t6_rst_valid", bus.o_Pkt_Valid, 0);
      checkOutput("t6_rst_byte",  bus.o_Pkt_Byte,  8'h00);
      checkOutput("t6_rst_last",  bus.o_Pkt_Last,  0);
      checkOutput("t6_rst_len",   bus.o_Pkt_Len,   8'h00);
      checkOutput("t6_rst_busy",  busy,            0);
      frame = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
      sendSeq(frame);
      checkOutput("t6_valid0", bus.o_Pkt_Valid, 1);
      checkOutput("t6_byte0",  bus.o_Pkt_Byte,  8'h10);
      checkOutput("t6_len",    bus.o_Pkt_Len,   8'h02);
      @(negedge clock);
      checkOutput("t6_byte1",  bus.o_Pkt_Byte,  8'h20);
      checkOutput("t6_last1",  bus.o_Pkt_Last,  1);
      @(negedge clock);
      checkOutput("t6_valid_end", bus.o_Pkt_Valid, 0);
      @(negedge clock);
      checkOutput("t6_no_errs", errTotal() - snapErr, 0);

      // Reset during replay drops valid on the next cycle
      bus.i_Pkt_Ready = 1'b0;
      frame = '{8'hA5, 8'h01, 8'h55, 8'h54};
      sendSeq(frame);
      checkOutput("t6_out_valid", bus.o_Pkt_Valid, 1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checkOutput("t6_outrst_valid", bus.o_Pkt_Valid, 0);
      checkOutput("t6_outrst_len",   bus.o_Pkt_Len,   8'h00);
      checkOutput("t6_outrst_busy",  busy,            0);

      repeat (2) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
